// File: rtl/fifo_async_wptr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous circular FIFO.
// Runs entirely in the write clock domain. It synchronizes the gray read
// pointer, then produces the RAM write enable and address, the binary and gray
// write pointers, full, fill level, almost-full and a sticky overflow flag.
// Optional feature: define FIFO_WPTR_OVF_CNT_EN to build a saturating 16-bit
// counter of rejected writes on ovf_cnt_out. When it is not defined,
// ovf_cnt_out is tied to zero.
module fifo_async_wptr_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  write_in,
  input  logic [ADDR_WIDTH:0]   rptr_g_async_in,
  input  logic [ADDR_WIDTH:0]   afull_thresh_in,
  input  logic                  ovf_clr_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] waddr_out,
  output logic [ADDR_WIDTH:0]   wptr_b_out,
  output logic [ADDR_WIDTH:0]   wptr_g_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   level_out,
  output logic                  overflow_out,
  output logic [15:0]           ovf_cnt_out
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]                  wptr_b_q, wptr_b_d;
  logic [PW-1:0]                  wptr_g_q, wptr_g_d;
  logic [PW-1:0]                  level_q, level_d;
  logic                           full_q, full_d;
  logic                           afull_q, afull_d;
  logic                           ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  rptr_b;
  logic                           accept;
  logic                           ovf_set;

  // A write is taken only when there is room. Requests made while reset is
  // asserted are never passed to the RAM.
  assign accept    = write_in & ~full_q & ~rst_in;
  assign ovf_set   = write_in & full_q;
  assign wr_en_out = accept;

  // Shift register that carries the read pointer across the clock domains.
  // The pointer is gray coded, so every stage sees at most one changing bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= rptr_g_async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Gray to binary conversion of the last synchronizer stage. Bit i is the
  // XOR of all gray bits at position i and above.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rptr_b[gi] = ^sync_q[SYNC_STAGES-1][PW-1:gi];
    end
  endgenerate

  // Next-state logic for the pointers and flags. Full and level use the
  // post-write pointer, so they settle on the same edge as the write.
  always_comb begin
    wptr_b_d = wptr_b_q + {{ADDR_WIDTH{1'b0}}, accept};
    wptr_g_d = wptr_b_d ^ (wptr_b_d >> 1);
    full_d   = (wptr_b_d == {~rptr_b[PW-1], rptr_b[PW-2:0]});
    level_d  = wptr_b_d - rptr_b;
    afull_d  = (level_d >= afull_thresh_in);
    ovf_d    = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_in) begin
      ovf_d = 1'b0;
    end
  end

  // Registers for the pointers and flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_b_q <= '0;
      wptr_g_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_b_q <= wptr_b_d;
      wptr_g_q <= wptr_g_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FIFO_WPTR_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Rejected-write counter. It saturates at all ones, and a clear request
  // takes priority over an increment in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr_in) begin
      cnt_d = 16'h0000;
    end else if (ovf_set && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end

  // Counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt_out = cnt_q;
`else
  assign ovf_cnt_out = 16'h0000;
`endif

  assign waddr_out       = wptr_b_q[ADDR_WIDTH-1:0];
  assign wptr_b_out      = wptr_b_q;
  assign wptr_g_out      = wptr_g_q;
  assign full_out        = full_q;
  assign almost_full_out = afull_q;
  assign level_out       = level_q;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_fifo_async_wptr_ctrl.sv
// Scoreboard bench for fifo_async_wptr_ctrl with ADDR_WIDTH=3 and SYNC_STAGES=2.
// The stimulus process drives inputs on the falling edge and queues the hand
// computed values expected at the next rising edge. The monitor pops the queue
// on each rising edge and compares. wr_en_out is sampled just before the edge,
// and the registered outputs are sampled 1 time unit after it.
module tb_fifo_async_wptr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_i;
  logic [3:0]  rptr_g;
  logic [3:0]  thresh;
  logic        clr;
  logic        wr_en;
  logic [2:0]  waddr;
  logic [3:0]  wptr_b;
  logic [3:0]  wptr_g;
  logic        full;
  logic        afull;
  logic [3:0]  level;
  logic        ovf;
  logic [15:0] ovf_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] val;
    string       name;
  } item_t;

  item_t sb[$];

  // Hand-tabulated gray codes for the binary values 0 to 15.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  fifo_async_wptr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .write_in        (write_i),
    .rptr_g_async_in (rptr_g),
    .afull_thresh_in (thresh),
    .ovf_clr_in      (clr),
    .wr_en_out       (wr_en),
    .waddr_out       (waddr),
    .wptr_b_out      (wptr_b),
    .wptr_g_out      (wptr_g),
    .full_out        (full),
    .almost_full_out (afull),
    .level_out       (level),
    .overflow_out    (ovf),
    .ovf_cnt_out     (ovf_cnt)
  );

  function automatic logic [15:0] cnt_e(input logic [15:0] v);
`ifdef FIFO_WPTR_OVF_CNT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  // Queue one expectation for the coming rising edge.
  task automatic chk(input string name, input int sel, input logic [15:0] val);
    item_t it;
    it.cyc  = cyc + 1;
    it.sel  = sel;
    it.val  = val;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic tick(input logic r, input logic w, input logic [3:0] rg, input logic c);
    @(negedge clk);
    rst     = r;
    write_i = w;
    rptr_g  = rg;
    clr     = c;
  endtask

  // Monitor: pops every expectation for this edge and compares it.
  initial begin
    logic        wren_s;
    logic [15:0] act;
    item_t       it;
    forever begin
      @(posedge clk);
      wren_s = wr_en;
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        case (it.sel)
          0:       act = {15'd0, wren_s};
          1:       act = {12'd0, wptr_b};
          2:       act = {12'd0, wptr_g};
          3:       act = {15'd0, full};
          4:       act = {12'd0, level};
          5:       act = {15'd0, afull};
          6:       act = {15'd0, ovf};
          7:       act = ovf_cnt;
          default: act = {13'd0, waddr};
        endcase
        vectors = vectors + 1;
        if (act !== it.val) begin
          miscompares = miscompares + 1;
          $display("FAIL %s cycle %0d: got %h expected %h", it.name, cyc, act, it.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; write_i = 1'b1; rptr_g = 4'h0; thresh = 4'd8; clr = 1'b0;

    // Reset held with write requested.
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 4'h0, 0);
      chk("rst_wren", 0, 0); chk("rst_wptr_b", 1, 0); chk("rst_wptr_g", 2, 0);
      chk("rst_full", 3, 0); chk("rst_level", 4, 0); chk("rst_ovf", 6, 0);
      chk("rst_cnt", 7, 0);
    end

    // Fill from empty: 10 write requests, 8 accepted.
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 4'h0, 0);
      chk("fill_wren", 0, (i <= 8) ? 16'd1 : 16'd0);
      if (i <= 8) begin
        chk("fill_wptr_b", 1, 16'(i));
        chk("fill_wptr_g", 2, {12'd0, gtab[i]});
        chk("fill_level", 4, 16'(i));
        chk("fill_full", 3, (i == 8) ? 16'd1 : 16'd0);
        chk("fill_waddr", 8, 16'(i % 8));
      end else begin
        chk("fill_hold_wptr_b", 1, 8);
        chk("fill_hold_full", 3, 1);
      end
      if (i == 8) chk("ovf_before", 6, 0);
      if (i == 9) chk("ovf_after", 6, 1);
      if (i == 10) chk("ovf_cnt2", 7, cnt_e(2));
    end

    // Overflow counter and clear behaviour.
    tick(0, 1, 4'h0, 0);
    chk("ovf_cnt3", 7, cnt_e(3)); chk("ovf_wren", 0, 0); chk("ovf_stick", 6, 1);
    tick(0, 0, 4'h0, 1);
    chk("clr_ovf", 6, 0); chk("clr_cnt", 7, 0);
    tick(0, 1, 4'h0, 1);
    chk("setclr_ovf", 6, 1); chk("setclr_cnt", 7, 0);
    tick(0, 0, 4'h0, 1);
    chk("clr2_ovf", 6, 0);

    // One read appears; full clears three edges later.
    tick(0, 0, 4'b0001, 0); chk("rd_e1_full", 3, 1); chk("rd_e1_level", 4, 8);
    tick(0, 0, 4'b0001, 0); chk("rd_e2_full", 3, 1); chk("rd_e2_level", 4, 8);
    tick(0, 0, 4'b0001, 0); chk("rd_e3_full", 3, 0); chk("rd_e3_level", 4, 7);
    tick(0, 1, 4'b0001, 0);
    chk("refill_wren", 0, 1); chk("refill_wptr_b", 1, 9);
    chk("refill_wptr_g", 2, 4'b1101); chk("refill_full", 3, 1); chk("refill_level", 4, 8);

    // Drain to empty (rptr = 9), then write across the pointer wrap.
    tick(0, 0, 4'b1101, 0);
    tick(0, 0, 4'b1101, 0);
    tick(0, 0, 4'b1101, 0); chk("drain_level", 4, 0); chk("drain_full", 3, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1, 4'b1101, 0);
      chk("wrap_wren", 0, 1);
      chk("wrap_wptr_b", 1, 16'((9 + k) % 16));
      chk("wrap_wptr_g", 2, {12'd0, gtab[(9 + k) % 16]});
      chk("wrap_level", 4, 16'(k));
      chk("wrap_full", 3, (k == 8) ? 16'd1 : 16'd0);
      chk("wrap_afull8", 5, (k == 8) ? 16'd1 : 16'd0);
    end
    tick(0, 0, 4'b1010, 0);
    tick(0, 0, 4'b1010, 0);
    tick(0, 0, 4'b1010, 0); chk("wrap_rd_level", 4, 5); chk("wrap_rd_full", 3, 0);

    // Almost-full at threshold 6 from empty (rptr = 1, wptr = 1).
    thresh = 4'd6;
    tick(0, 0, 4'b0001, 0);
    tick(0, 0, 4'b0001, 0);
    tick(0, 0, 4'b0001, 0); chk("af_empty_level", 4, 0); chk("af_empty", 5, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 1, 4'b0001, 0);
      chk("af_level", 4, 16'(k));
      chk("af_flag", 5, (k == 6) ? 16'd1 : 16'd0);
    end
    tick(0, 0, 4'b0001, 0); thresh = 4'd0; chk("af_thresh0", 5, 1);
    tick(0, 0, 4'b0001, 0); thresh = 4'd9; chk("af_thresh9", 5, 0);

    // Reset in the middle of operation.
    tick(1, 1, 4'b0001, 0);
    chk("mrst_wren", 0, 0); chk("mrst_wptr_b", 1, 0); chk("mrst_level", 4, 0);
    chk("mrst_full", 3, 0); chk("mrst_afull", 5, 0);

`ifdef FIFO_WPTR_OVF_CNT_EN
    // Saturation: fill, then keep writing while full until the counter tops out.
    tick(1, 0, 4'h0, 0);
    for (int k = 0; k < 8; k++) tick(0, 1, 4'h0, 0);
    chk("sat_full", 3, 1);
    for (int k = 0; k < 65535; k++) tick(0, 1, 4'h0, 0);
    chk("sat_reach", 7, 16'hFFFF);
    tick(0, 1, 4'h0, 0);
    chk("sat_hold", 7, 16'hFFFF);
`endif

    tick(0, 0, 4'h0, 0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      miscompares = miscompares + sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
